seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier_if.sv | 25 ++
 rtl/seq_multiplier.sv | 125 ++++++++++++
 tb/tb_seq_multiplier.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_if.sv
// Handshake and data bundle for the sequential multiplier.
// The master drives operands and accepts products; the slave is the multiplier.
interface seq_multiplier_if #(
    parameter int WIDTH = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               signed_mode;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] p;
    logic               busy;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/seq_multiplier.sv
// Shift-and-add multiplier, one multiplier bit per clock.
// Signed operands are reduced to magnitudes on capture and the sign is
// reapplied when the product is loaded, so both modes share one datapath.
module seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    seq_multiplier_if.slave   bus
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [PW-1:0]   acc_q;
    logic [PW-1:0]   acc_d;
    logic [PW-1:0]   accNeg_d;
    logic [CW-1:0]   cnt_q;
    logic            neg_q;
    logic [PW-1:0]   p_q;
    logic            inReady_q;
    logic            outValid_q;
    logic            busy_q;

    logic [WIDTH-1:0] aMag_d;
    logic [WIDTH-1:0] bMag_d;
    logic             neg_d;

    // Operand magnitudes and result sign as they would be captured this cycle.
    // The most negative value maps to itself, which read as unsigned is its magnitude.
    always_comb begin
        aMag_d = bus.a;
        bMag_d = bus.b;
        neg_d  = 1'b0;
        if (bus.signed_mode) begin
            if (bus.a[WIDTH-1]) begin
                aMag_d = ~bus.a + WIDTH'(1);
            end
            if (bus.b[WIDTH-1]) begin
                bMag_d = ~bus.b + WIDTH'(1);
            end
            neg_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
        end
    end

    // Next accumulator value for the current multiplier bit, and its negation for the final load.
    always_comb begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        accNeg_d = ~acc_q + PW'(1);
    end

    // Control FSM with registered handshake outputs and the datapath registers.
    // CALC spends WIDTH cycles adding, then one more cycle loading p, giving a
    // fixed WIDTH+1 edge latency from acceptance to out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            p_q        <= '0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand_q   <= {{WIDTH{1'b0}}, aMag_d};
                        mplier_q  <= bMag_d;
                        neg_q     <= neg_d;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        state_q   <= CALC;
                        inReady_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                CALC: begin
                    if (cnt_q == CW'(WIDTH)) begin
                        p_q        <= neg_q ? accNeg_d : acc_q;
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        outValid_q <= 1'b1;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q    <= IDLE;
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    inReady_q  <= 1'b1;
                    outValid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = inReady_q;
    assign bus.out_valid = outValid_q;
    assign bus.busy      = busy_q;
    assign bus.p         = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and random checks of seq_multiplier at WIDTH = 16.
module tb_seq_multiplier;

    localparam int WIDTH   = 16;
    localparam int LATENCY = WIDTH + 1;

    typedef struct {
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic               mode;
        logic [2*WIDTH-1:0] expP;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs[12];

    seq_multiplier_if #(.WIDTH(WIDTH)) bus ();

    seq_multiplier #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // One complete transaction: wait for in_ready, present operands, measure latency,
    // hold the result for holdCycles, then accept it.
    task automatic applyStimulus(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                 input logic vm, input logic [2*WIDTH-1:0] expP,
                                 input int holdCycles, input string name);
        int waitN;
        int lat;
        waitN = 0;
        while (bus.in_ready !== 1'b1 && waitN < 50) begin
            @(posedge clk);
            #1;
            waitN++;
        end
        checkOutput({name, " in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.a           = va;
        bus.b           = vb;
        bus.signed_mode = vm;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b0;
        bus.a           = WIDTH'($urandom);
        bus.b           = WIDTH'($urandom);
        bus.signed_mode = ~vm;
        checkOutput({name, " busy"}, 64'(bus.busy), 64'd1);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (bus.out_valid !== 1'b1 && lat < 100);
        checkOutput({name, " latency"}, 64'(lat), 64'(LATENCY));
        checkOutput({name, " p"}, 64'(bus.p), 64'(expP));
        repeat (holdCycles) begin
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput({name, " out_valid drop"}, 64'(bus.out_valid), 64'd0);
        checkOutput({name, " idle in_ready"}, 64'(bus.in_ready), 64'd1);
        checkOutput({name, " p held"}, 64'(bus.p), 64'(expP));
    endtask

    initial begin
        int  lat;
        bit  sawValid;
        logic [WIDTH-1:0]   ra;
        logic [WIDTH-1:0]   rb;
        logic               rm;
        logic [2*WIDTH-1:0] refP;
        longint             sa;
        longint             sb;

        checks = 0;
        errors = 0;

        vecs[0]  = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
        vecs[1]  = '{16'h8000, 16'h8000, 1'b1, 32'h40000000};
        vecs[2]  = '{16'h8000, 16'h0001, 1'b1, 32'hFFFF8000};
        vecs[3]  = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001};
        vecs[4]  = '{16'h0000, 16'h8000, 1'b1, 32'h00000000};
        vecs[5]  = '{16'h0003, 16'h0005, 1'b0, 32'h0000000F};
        vecs[6]  = '{16'h1234, 16'h0010, 1'b0, 32'h00012340};
        vecs[7]  = '{16'hFFFE, 16'h0003, 1'b1, 32'hFFFFFFFA};
        vecs[8]  = '{16'h8000, 16'h0002, 1'b0, 32'h00010000};
        vecs[9]  = '{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001};
        vecs[10] = '{16'h7FFF, 16'h8000, 1'b1, 32'hC0008000};
        vecs[11] = '{16'h00FF, 16'h0100, 1'b0, 32'h0000FF00};

        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.signed_mode = 1'b0;
        bus.out_ready   = 1'b0;

        #12;
        checkOutput("reset in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("reset busy", 64'(bus.busy), 64'd0);
        checkOutput("reset p", 64'(bus.p), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed vectors");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].expP, i % 3,
                          $sformatf("vec%0d", i));
        end

        $display("[TB] back-pressure with operand changes in DONE");
        bus.a           = 16'hFFFF;
        bus.b           = 16'hFFFF;
        bus.signed_mode = 1'b0;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (bus.out_valid !== 1'b1 && lat < 100);
        checkOutput("bp latency", 64'(lat), 64'(LATENCY));
        for (int i = 0; i < 10; i++) begin
            bus.in_valid    = 1'b1;
            bus.a           = WIDTH'(16'h0101 * (i + 1));
            bus.b           = WIDTH'(16'h0203 * (i + 2));
            bus.signed_mode = i[0];
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp p cycle%0d", i), 64'(bus.p), 64'h00000000FFFE0001);
            checkOutput($sformatf("bp in_ready cycle%0d", i), 64'(bus.in_ready), 64'd0);
            checkOutput($sformatf("bp out_valid cycle%0d", i), 64'(bus.out_valid), 64'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput("bp release in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("bp release busy", 64'(bus.busy), 64'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("bp no capture busy", 64'(bus.busy), 64'd0);
        checkOutput("bp no capture p", 64'(bus.p), 64'h00000000FFFE0001);

        $display("[TB] reset during CALC");
        bus.a           = 16'h1234;
        bus.b           = 16'h5678;
        bus.signed_mode = 1'b0;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        checkOutput("pre-reset busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("async reset in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("async reset out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("async reset busy", 64'(bus.busy), 64'd0);
        checkOutput("async reset p", 64'(bus.p), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        sawValid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) sawValid = 1'b1;
        end
        checkOutput("no out_valid after reset", 64'(sawValid), 64'd0);
        applyStimulus(16'd3, 16'd5, 1'b0, 32'd15, 0, "post-reset 3x5");

        $display("[TB] random back-to-back regression");
        for (int i = 0; i < 200; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rm = 1'($urandom_range(0, 1));
            if (rm) begin
                sa   = longint'($signed(ra));
                sb   = longint'($signed(rb));
                refP = (2*WIDTH)'(sa * sb);
            end else begin
                sa   = longint'(ra);
                sb   = longint'(rb);
                refP = (2*WIDTH)'(sa * sb);
            end
            applyStimulus(ra, rb, rm, refP, $urandom_range(0, 3), $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
